// File: rtl/aqed_pkg.sv
// Shared types and default sizing for the A-QED response checker.
package aqed_pkg;

   localparam int AQED_DATA_W = 16;
   localparam int AQED_CNT_W  = 16;
   localparam int AQED_BOUND  = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      COLLECT = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/aqed_timeout_ctr.sv
// Response-bound monitor: flags a tile that sees BOUND enabled cycles in a row
// without a response beat. Only instantiated when AQED_TIMEOUT_EN is defined.
module aqed_timeout_ctr #(
   parameter int CNT_W = 16,
   parameter int BOUND = 64
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clk_en,
   input  logic clear,
   input  logic active,
   input  logic beat,
   output logic timeout
);

   localparam logic [CNT_W-1:0] BOUND_C = CNT_W'(BOUND);

   logic [CNT_W-1:0] idle_cnt;

   // The counter saturates at BOUND so a stalled tile never wraps back to a clean count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else if (clk_en) begin
         if (clear) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
         end else if (active) begin
            if (beat) begin
               idle_cnt <= '0;
            end else if (idle_cnt != BOUND_C) begin
               idle_cnt <= idle_cnt + CNT_W'(1);
               if (idle_cnt + CNT_W'(1) == BOUND_C) timeout <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/aqed_resp_checker.sv
// A-QED response checker: reads one tile, captures the original and duplicate
// beats and compares them. Optional response-bound monitor: AQED_TIMEOUT_EN.
module aqed_resp_checker
   import aqed_pkg::*;
#(
   parameter int DATA_W = AQED_DATA_W,
   parameter int CNT_W  = AQED_CNT_W,
   parameter int BOUND  = AQED_BOUND
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clk_en,
   input  logic              start,
   input  logic [CNT_W-1:0]  depth,
   input  logic [CNT_W-1:0]  orig_idx,
   input  logic [CNT_W-1:0]  dup_idx,
   output logic              ren_out,
   input  logic              acc_valid,
   input  logic [DATA_W-1:0] acc_data,
   output logic              busy,
   output logic              qed_done,
   output logic              qed_check,
   output logic              timeout,
   output state_t            dbg_state
);

   state_t              state;
   logic [CNT_W-1:0]    rd_cnt;
   logic [CNT_W-1:0]    rsp_cnt;
   logic [CNT_W-1:0]    rsp_cnt_nxt;
   logic                orig_seen;
   logic                dup_seen;
   logic [DATA_W-1:0]   orig_reg;
   logic [DATA_W-1:0]   dup_reg;
   logic                beat;
   logic                start_acc;

   // The memory side has no ready: a beat counts in any enabled ISSUE/COLLECT
   // cycle where acc_valid is high, until depth beats have been taken.
   assign busy        = (state == ISSUE) || (state == COLLECT);
   assign ren_out     = (state == ISSUE) && clk_en && (rd_cnt < depth);
   assign beat        = busy && clk_en && acc_valid && (rsp_cnt < depth);
   assign rsp_cnt_nxt = beat ? rsp_cnt + CNT_W'(1) : rsp_cnt;
   assign start_acc   = clk_en && start && ((state == IDLE) || (state == DONE));
   assign dbg_state   = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         rd_cnt    <= '0;
         rsp_cnt   <= '0;
         orig_seen <= 1'b0;
         dup_seen  <= 1'b0;
         orig_reg  <= '0;
         dup_reg   <= '0;
         qed_done  <= 1'b0;
         qed_check <= 1'b0;
      end else if (clk_en) begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= ISSUE;
                  rd_cnt    <= '0;
                  rsp_cnt   <= '0;
                  orig_seen <= 1'b0;
                  dup_seen  <= 1'b0;
                  qed_done  <= 1'b0;
                  qed_check <= 1'b0;
               end
            end
            ISSUE: begin
               if (ren_out) begin
                  rd_cnt <= rd_cnt + CNT_W'(1);
                  if (rd_cnt + CNT_W'(1) == depth) state <= COLLECT;
               end
            end
            COLLECT: begin
               if (rsp_cnt_nxt == depth) state <= DONE;
            end
            DONE: begin
               if (start) begin
                  state     <= IDLE;
                  orig_seen <= 1'b0;
                  dup_seen  <= 1'b0;
                  qed_done  <= 1'b0;
                  qed_check <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         if (beat) begin
            rsp_cnt <= rsp_cnt_nxt;
            if (rsp_cnt == orig_idx) begin
               orig_reg  <= acc_data;
               orig_seen <= 1'b1;
            end
            if (rsp_cnt == dup_idx) begin
               dup_reg  <= acc_data;
               dup_seen <= 1'b1;
            end
         end

         // Verdict is taken one cycle after the second capture so both registers are settled.
         if (!start_acc && (state != IDLE) && orig_seen && dup_seen && !qed_done) begin
            qed_done  <= 1'b1;
            qed_check <= (orig_reg == dup_reg);
         end
      end
   end

`ifdef AQED_TIMEOUT_EN
   aqed_timeout_ctr #(
      .CNT_W (CNT_W),
      .BOUND (BOUND)
   ) u_timeout_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .clk_en  (clk_en),
      .clear   (start_acc),
      .active  (busy),
      .beat    (acc_valid),
      .timeout (timeout)
   );
`else
   logic unused_bound;
   assign unused_bound = (BOUND > 0);
   assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_aqed_resp_checker.sv
// Bench for aqed_resp_checker: one-cycle-latency memory model feeding tiles,
// expected {qed_done, qed_check} queued per tile and compared at DONE.
module tb_aqed_resp_checker;
   import aqed_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        clk_en = 1'b0;
   logic        start = 1'b0;
   logic [15:0] depth = 16'd1;
   logic [15:0] orig_idx = '0;
   logic [15:0] dup_idx = '0;
   logic        ren_out;
   logic        acc_valid = 1'b0;
   logic [15:0] acc_data = '0;
   logic        busy;
   logic        qed_done;
   logic        qed_check;
   logic        timeout;
   state_t      dbg_state;

   int          n_checks = 0;
   int          n_fail = 0;
   bit          have_done = 1'b0;
   logic [1:0]  exp_q[$];
   logic [1:0]  last_exp = '0;
   logic [15:0] beat_data[0:63];

   aqed_resp_checker #(
      .DATA_W (16),
      .CNT_W  (16),
      .BOUND  (8)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clk_en    (clk_en),
      .start     (start),
      .depth     (depth),
      .orig_idx  (orig_idx),
      .dup_idx   (dup_idx),
      .ren_out   (ren_out),
      .acc_valid (acc_valid),
      .acc_data  (acc_data),
      .busy      (busy),
      .qed_done  (qed_done),
      .qed_check (qed_check),
      .timeout   (timeout),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic pulse_start();
      @(negedge clk);
      clk_en = 1'b1;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      n_checks++;
      if ({ren_out, busy, qed_done, qed_check, timeout} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 00000", {ren_out, busy, qed_done, qed_check, timeout});
      end
      n_checks++;
      if (dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // mode: 0 = orig/dup beats equal, 1 = dup beat is orig ^ 1, 2 = all random
   task automatic run_tile(input string name, input int d, input int oi, input int di,
                           input int mode, input bit toggle);
      int      resp_q[$];
      int      reqs;
      int      cyc;
      bit      finished;
      bit      hold_chk;
      state_t  held;
      bit      exp_done;
      bit      exp_check;
      logic [1:0] exp;

      for (int i = 0; i < d; i++) beat_data[i] = 16'($urandom_range(0, 65535));
      if (oi < d && di < d && oi != di) begin
         if (mode == 0) beat_data[di] = beat_data[oi];
         else if (mode == 1) beat_data[di] = beat_data[oi] ^ 16'h0001;
      end
      exp_done  = (oi < d) && (di < d);
      exp_check = exp_done && (beat_data[oi] == beat_data[di]);
      exp_q.push_back({exp_done, exp_check});

      depth    = 16'(d);
      orig_idx = 16'(oi);
      dup_idx  = 16'(di);

      if (have_done) begin
         pulse_start();
         n_checks++;
         if (qed_done !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL %s release: got done=%b state=%0d expected done=0 state=%0d",
                     name, qed_done, dbg_state, IDLE);
         end
      end
      pulse_start();

      reqs = 0;
      finished = 1'b0;
      hold_chk = 1'b0;
      held = IDLE;
      cyc = 0;
      while (!finished && cyc < 400) begin
         if (hold_chk) begin
            n_checks++;
            if (dbg_state !== held) begin
               n_fail++;
               $display("FAIL %s hold_state: got %0d expected %0d", name, dbg_state, held);
            end
         end
         clk_en = toggle ? ((cyc % 2) == 0) : 1'b1;
         if (clk_en && resp_q.size() > 0) begin
            acc_valid = 1'b1;
            acc_data  = beat_data[resp_q.pop_front()];
         end else begin
            acc_valid = 1'b0;
            acc_data  = 16'($urandom_range(0, 65535));
         end
         #1;
         if (!busy) begin
            finished = 1'b1;
         end else begin
            if (ren_out) begin
               if (toggle) begin
                  n_checks++;
                  if (clk_en !== 1'b1) begin
                     n_fail++;
                     $display("FAIL %s ren_when_disabled: got clk_en=%b expected 1", name, clk_en);
                  end
               end
               resp_q.push_back(reqs);
               reqs++;
            end
            hold_chk = !clk_en;
            held = dbg_state;
            @(negedge clk);
            cyc++;
         end
      end
      acc_valid = 1'b0;
      clk_en = 1'b1;

      n_checks++;
      if (!finished) begin
         n_fail++;
         $display("FAIL %s done_bound: got busy=%b after %0d cycles expected 0", name, busy, cyc);
      end
      repeat (2) @(negedge clk);

      exp = exp_q.pop_front();
      last_exp = exp;
      n_checks++;
      if (qed_done !== exp[1]) begin
         n_fail++;
         $display("FAIL %s qed_done: got %b expected %b", name, qed_done, exp[1]);
      end
      if (exp[1]) begin
         n_checks++;
         if (qed_check !== exp[0]) begin
            n_fail++;
            $display("FAIL %s qed_check: got %b expected %b", name, qed_check, exp[0]);
         end
      end
      n_checks++;
      if (reqs != d) begin
         n_fail++;
         $display("FAIL %s ren_count: got %0d expected %0d", name, reqs, d);
      end
      n_checks++;
      if (dbg_state !== DONE || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL %s end_state: got state=%0d timeout=%b expected state=%0d timeout=0",
                  name, dbg_state, timeout, DONE);
      end
      have_done = 1'b1;
   endtask

   task automatic test_match();
      run_tile("match_d9", 9, 2, 7, 0, 1'b0);
   endtask

   task automatic test_mismatch();
      run_tile("mismatch_d9", 9, 2, 7, 1, 1'b0);
   endtask

   task automatic test_clk_en_toggle();
      run_tile("toggle_d4", 4, 1, 3, 0, 1'b1);
   endtask

   task automatic test_same_index();
      run_tile("same_idx_d5", 5, 3, 3, 2, 1'b0);
   endtask

   task automatic test_index_out_of_range();
      run_tile("orig_oor_d9", 9, 9, 4, 0, 1'b0);
      run_tile("min_depth_d1", 1, 0, 0, 2, 1'b0);
   endtask

   task automatic test_extra_beats();
      run_tile("extra_base", 6, 0, 5, 1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         acc_valid = 1'b1;
         acc_data  = 16'($urandom_range(0, 65535));
      end
      @(negedge clk);
      acc_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({qed_done, qed_check} !== last_exp || dbg_state !== DONE) begin
         n_fail++;
         $display("FAIL extra_beats: got done/check=%b state=%0d expected %b state=%0d",
                  {qed_done, qed_check}, dbg_state, last_exp, DONE);
      end
   endtask

   task automatic test_random_tiles();
      for (int t = 0; t < 4; t++) begin
         int d;
         d = $urandom_range(1, 12);
         run_tile("random_tile", d, $urandom_range(0, d), $urandom_range(0, d - 1),
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_reset_mid_tile();
      int  beats;
      int  cyc;
      bit  prev_ren;
      depth    = 16'd9;
      orig_idx = 16'd2;
      dup_idx  = 16'd7;
      if (have_done) pulse_start();
      pulse_start();
      beats = 0;
      cyc = 0;
      prev_ren = 1'b0;
      while (beats < 3 && cyc < 50) begin
         clk_en    = 1'b1;
         acc_valid = prev_ren;
         acc_data  = 16'h5a5a;
         if (acc_valid) beats++;
         #1;
         prev_ren = ren_out;
         @(negedge clk);
         cyc++;
      end
      acc_valid = 1'b0;
      n_checks++;
      if (beats != 3 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_setup: got beats=%0d busy=%b expected 3 and 1", beats, busy);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({ren_out, busy, qed_done, qed_check, timeout} !== 5'b0 || dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got %b state=%0d expected 00000 state=%0d",
                  {ren_out, busy, qed_done, qed_check, timeout}, dbg_state, IDLE);
      end
      @(negedge clk);
      reset_n = 1'b1;
      have_done = 1'b0;
      run_tile("after_reset", 9, 2, 7, 0, 1'b0);
   endtask

`ifdef AQED_TIMEOUT_EN
   task automatic test_timeout();
      depth    = 16'd9;
      orig_idx = 16'd2;
      dup_idx  = 16'd7;
      if (have_done) pulse_start();
      pulse_start();
      clk_en    = 1'b1;
      acc_valid = 1'b0;
      repeat (7) @(negedge clk);
      n_checks++;
      if (timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_early: got %b expected 0", timeout);
      end
      @(negedge clk);
      n_checks++;
      if (timeout !== 1'b1 || qed_done !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_bound: got timeout=%b done=%b expected 1 and 0", timeout, qed_done);
      end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      have_done = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_match();
      test_mismatch();
      test_clk_en_toggle();
      test_same_index();
      test_index_out_of_range();
      test_extra_beats();
      test_reset_mid_tile();
      test_random_tiles();
`ifdef AQED_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aqed_resp_checker.md
AQED_RESP_CHECKER -- requirements
Module: aqed_resp_checker

Interface
REQ-001 Parameter DATA_W, default 16: width of the response data beat.
REQ-002 Parameter CNT_W, default 16: width of the depth, index and beat counters.
REQ-003 Parameter BOUND, default 64: response-bound limit in enabled cycles; used only when AQED_TIMEOUT_EN is defined.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port clk_en, input, 1: global enable; state holds when low.
REQ-007 Port start, input, 1: one-cycle pulse that arms a tile readout.
REQ-008 Port depth, input, CNT_W: beats per tile; must be greater than 0 and stable while busy.
REQ-009 Port orig_idx, input, CNT_W: beat index of the original transaction.
REQ-010 Port dup_idx, input, CNT_W: beat index of the duplicate transaction.
REQ-011 Port ren_out, output, 1: read request to the double-buffer read port.
REQ-012 Port acc_valid, input, 1: response beat valid from the memory core.
REQ-013 Port acc_data, input, DATA_W: response beat data.
REQ-014 Port busy, output, 1: high in the ISSUE and COLLECT states.
REQ-015 Port qed_done, output, 1: sticky; orig and dup beats both captured.
REQ-016 Port qed_check, output, 1: orig capture equals dup capture; meaningful only while qed_done is high.
REQ-017 Port timeout, output, 1: sticky response-bound violation; driven constant 0 when AQED_TIMEOUT_EN is undefined.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, ISSUE, COLLECT and DONE.
REQ-019 IDLE SHALL go to ISSUE on start && clk_en, clearing rd_cnt, rsp_cnt, both capture flags, qed_done and timeout.
REQ-020 ren_out SHALL be combinational and equal to (state == ISSUE) && clk_en && (rd_cnt < depth).
- Each asserted ren_out increments rd_cnt.
- Exactly depth requests are issued per tile.
REQ-021 ISSUE SHALL go to COLLECT in the cycle rd_cnt reaches depth.
REQ-022 Each acc_valid && clk_en beat SHALL increment rsp_cnt in ISSUE and COLLECT, with no assumed read latency.
- Beats in IDLE or DONE are ignored.
REQ-023 A beat with rsp_cnt == orig_idx SHALL load orig_reg and set orig_seen.
- A beat with rsp_cnt == dup_idx SHALL load dup_reg and set dup_seen.
- If orig_idx == dup_idx, the same beat loads both registers.
REQ-024 qed_done SHALL rise in the cycle after both flags are set.
- qed_check SHALL equal (orig_reg == dup_reg), registered in that same cycle.
REQ-025 COLLECT SHALL go to DONE when rsp_cnt reaches depth.
- DONE SHALL return to IDLE on the next start; qed_done and qed_check hold until then.
REQ-026 Beats beyond depth SHALL NOT change rsp_cnt or the capture registers.
REQ-027 Index values >= depth SHALL never capture; qed_done then stays 0.
REQ-028 start SHALL be ignored outside IDLE and DONE.
REQ-029 Counters SHALL be CNT_W bits wide, compare unsigned, and never wrap, because they saturate at depth.

Reset
REQ-030 Asserting reset_n low SHALL immediately force:
- state to IDLE;
- ren_out, busy, qed_done, qed_check and timeout to 0;
- all counters, flags and data registers to 0.
REQ-031 Reset mid-tile SHALL abandon the tile; no output reflects the partial result after release.

Configuration
REQ-032 With macro AQED_TIMEOUT_EN defined, a counter SHALL count clk_en cycles in ISSUE/COLLECT with no acc_valid.
- The counter clears on each beat.
- timeout sets when the counter reaches BOUND.
- timeout holds until the next start or reset.
REQ-033 Without AQED_TIMEOUT_EN, the timeout logic SHALL be absent and timeout SHALL be tied to 0.

Structure
REQ-034 Package aqed_pkg SHALL hold the FSM state enum and the default DATA_W/CNT_W/BOUND constants.
REQ-035 The timeout logic SHALL be one sub-module, aqed_timeout_ctr, instantiated only under AQED_TIMEOUT_EN.

Verification
REQ-036 depth=9, orig_idx=2, dup_idx=7, identical beat data, one-cycle latency -> exactly 9 ren_out pulses, then qed_done=1 and qed_check=1.
REQ-037 Same setup, but beat 7 data = beat 2 data ^ 16'h0001 -> qed_done=1 and qed_check=0.
REQ-038 depth=4, clk_en toggled every other cycle -> 4 ren_out pulses, each only in a clk_en-high cycle; state holds in the clk_en-low cycles.
REQ-039 reset_n pulsed low after 3 of 9 beats -> all outputs read 0 immediately; a fresh start then completes normally.
REQ-040 AQED_TIMEOUT_EN defined, BOUND=8, no acc_valid after start -> timeout=1 on the 8th enabled cycle and qed_done=0.
REQ-041 orig_idx=9 with depth=9 -> DONE is reached and qed_done stays 0.
